// File: rtl/horizontal_counter.sv
// ---------------------------------------------------------------------------
// horizontal_counter
//
// Pixel-column timing generator for the 640x480@60 VGA path. One scan line is
// walked as active -> front porch -> sync -> back porch by an explicit FSM
// that steps on the 25 MHz pixel clock. Every output is registered and is
// computed from the next count, so all outputs line up with H_Count_Value.
//
// Ports
//   clk_25Mhz         in   1   pixel clock, rising edge
//   rst_n             in   1   asynchronous, active-low reset
//   run               in   1   1 = advance one column per clock, 0 = freeze
//   H_Count_Value     out  16  current column, 0..H_TOTAL-1
//   enable_V_Counter  out  1   one-cycle end-of-line strobe (count = H_TOTAL-1)
//   hsync             out  1   horizontal sync, asserted level = HSYNC_POL
//   h_video_on        out  1   1 while the column is in the active region
//   pixel_x           out  10  column inside the active region, 0 when blanked
// ---------------------------------------------------------------------------
module horizontal_counter #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter logic HSYNC_POL = 1'b0
) (
  input  logic        clk_25Mhz,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] H_Count_Value,
  output logic        enable_V_Counter,
  output logic        hsync,
  output logic        h_video_on,
  output logic [9:0]  pixel_x
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Column numbers at which each region begins, and the last column.
  localparam logic [15:0] FP_START   = 16'(H_ACTIVE);
  localparam logic [15:0] SYNC_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] BP_START   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] LAST_COL   = 16'(H_TOTAL - 1);

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_FP     = 2'd1,
    S_SYNC   = 2'd2,
    S_BP     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        state_bad;
  logic [15:0] count_next;

  // The >= guard also folds any out-of-range count back to column 0.
  always_comb begin
    count_next = (H_Count_Value >= LAST_COL) ? 16'd0 : H_Count_Value + 16'd1;
  end

  // Region transitions are taken on the column we are about to enter, which
  // is what keeps the registered decode coincident with the count.
  always_comb begin
    state_next = state;
    state_bad  = 1'b0;
    case (state)
      S_ACTIVE: if (count_next == FP_START)   state_next = S_FP;
      S_FP:     if (count_next == SYNC_START) state_next = S_SYNC;
      S_SYNC:   if (count_next == BP_START)   state_next = S_BP;
      S_BP:     if (count_next == 16'd0)      state_next = S_ACTIVE;
      default: begin
        state_next = S_ACTIVE;
        state_bad  = 1'b1;
      end
    endcase
  end

  // ---- register stage: count, FSM state and decoded outputs ----
  always_ff @(posedge clk_25Mhz or negedge rst_n) begin
    if (!rst_n) begin
      H_Count_Value    <= 16'd0;
      state            <= S_ACTIVE;
      enable_V_Counter <= 1'b0;
      h_video_on       <= 1'b0;
      pixel_x          <= 10'd0;
      hsync            <= ~HSYNC_POL;
    end else if (state_bad) begin
      // Corrupted state: restart the line at column 0 of the active region.
      H_Count_Value    <= 16'd0;
      state            <= S_ACTIVE;
      enable_V_Counter <= 1'b0;
      h_video_on       <= 1'b1;
      pixel_x          <= 10'd0;
      hsync            <= ~HSYNC_POL;
    end else if (run) begin
      H_Count_Value    <= count_next;
      state            <= state_next;
      // Only an advancing edge can raise the strobe, so a line that is held
      // at its last column never produces a second pulse.
      enable_V_Counter <= (count_next == LAST_COL);
      h_video_on       <= (state_next == S_ACTIVE);
      hsync            <= (state_next == S_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      pixel_x          <= (state_next == S_ACTIVE) ? count_next[9:0] : 10'd0;
    end else begin
      enable_V_Counter <= 1'b0;
    end
  end

endmodule

// File: tb/tb_horizontal_counter.sv
// ---------------------------------------------------------------------------
// tb_horizontal_counter
//
// Runs a default 640x480 instance and a small HSYNC_POL=1 instance side by
// side, comparing every output each cycle against a column-level model.
// ---------------------------------------------------------------------------
module tb_horizontal_counter;

  logic clk_25Mhz = 1'b0;
  always #20 clk_25Mhz = ~clk_25Mhz;

  logic        rst_n, run, rst_n_s, run_s;
  logic [15:0] cnt, cnt_s;
  logic        stb, hs, vid, stb_s, hs_s, vid_s;
  logic [9:0]  px, px_s;

  horizontal_counter dut (
    .clk_25Mhz(clk_25Mhz), .rst_n(rst_n), .run(run),
    .H_Count_Value(cnt), .enable_V_Counter(stb), .hsync(hs),
    .h_video_on(vid), .pixel_x(px)
  );

  horizontal_counter #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .HSYNC_POL(1'b1)
  ) dut_s (
    .clk_25Mhz(clk_25Mhz), .rst_n(rst_n_s), .run(run_s),
    .H_Count_Value(cnt_s), .enable_V_Counter(stb_s), .hsync(hs_s),
    .h_video_on(vid_s), .pixel_x(px_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---- reference model: one entry per instance (0 = default, 1 = small) ----
  int m_cnt[2];
  bit m_fresh[2];   // no advancing edge since reset: column 0 still blanked
  bit m_stb[2];

  function automatic int p_act(input int i);  return (i == 0) ? 640 : 8; endfunction
  function automatic int p_fp(input int i);   return (i == 0) ? 16  : 2; endfunction
  function automatic int p_sync(input int i); return (i == 0) ? 96  : 3; endfunction
  function automatic int p_tot(input int i);  return (i == 0) ? 800 : 16; endfunction
  function automatic bit p_pol(input int i);  return (i == 0) ? 1'b0 : 1'b1; endfunction

  task automatic model_reset(input int i);
    m_cnt[i] = 0; m_fresh[i] = 1'b1; m_stb[i] = 1'b0;
  endtask

  task automatic model_edge(input int i, input bit r);
    int last;
    last = p_tot(i) - 1;
    if (r) begin
      m_cnt[i]   = (m_cnt[i] == last) ? 0 : m_cnt[i] + 1;
      m_fresh[i] = 1'b0;
      m_stb[i]   = (m_cnt[i] == last);
    end else begin
      m_stb[i] = 1'b0;
    end
  endtask

  task automatic check_dut(input int i);
    int c, sync_lo, px_e;
    bit vid_e, hs_e;
    c       = m_cnt[i];
    sync_lo = p_act(i) + p_fp(i);
    vid_e   = (c < p_act(i)) && !m_fresh[i];
    hs_e    = (c >= sync_lo && c < sync_lo + p_sync(i)) ? p_pol(i) : !p_pol(i);
    px_e    = vid_e ? c : 0;
    if (i == 0) begin
      chk("count", 32'(cnt), c);
      chk("strobe", 32'(stb), int'(m_stb[0]));
      chk("hsync", 32'(hs), int'(hs_e));
      chk("video_on", 32'(vid), int'(vid_e));
      chk("pixel_x", 32'(px), px_e);
    end else begin
      chk("s_count", 32'(cnt_s), c);
      chk("s_strobe", 32'(stb_s), int'(m_stb[1]));
      chk("s_hsync", 32'(hs_s), int'(hs_e));
      chk("s_video_on", 32'(vid_s), int'(vid_e));
      chk("s_pixel_x", 32'(px_s), px_e);
    end
  endtask

  // One clock for both instances; checks land 1 ns after the rising edge.
  task automatic step(input bit r0, input bit r1);
    run   = r0;
    run_s = r1;
    @(posedge clk_25Mhz);
    model_edge(0, r0);
    model_edge(1, r1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs are
  // checked while reset is still low, before any further edge.
  task automatic pulse_reset(input bit b0, input bit b1);
    #5;
    if (b0) rst_n = 1'b0;
    if (b1) rst_n_s = 1'b0;
    #1;
    if (b0) model_reset(0);
    if (b1) model_reset(1);
    check_dut(0);
    check_dut(1);
    #5;
    rst_n   = 1'b1;
    rst_n_s = 1'b1;
  endtask

  int pulses, hs_low, s_hs_high;

  initial begin
    rst_n = 1'b1; rst_n_s = 1'b1; run = 1'b0; run_s = 1'b0;
    pulse_reset(1'b1, 1'b1);

    // Two full lines on the default instance.
    pulses = 0; hs_low = 0; s_hs_high = 0;
    for (int k = 0; k < 1599; k++) begin
      step(1'b1, 1'b1);
      if (stb) pulses++;
      if (!hs) hs_low++;
      if (hs_s) s_hs_high++;
      if (cnt == 16'd639) chk("px_at_639", 32'(px), 639);
      if (cnt == 16'd640) begin
        chk("px_at_640", 32'(px), 0);
        chk("vid_at_640", 32'(vid), 0);
      end
      if (cnt_s >= 16'd10 && cnt_s <= 16'd12) chk("s_sync_window", 32'(hs_s), 1);
      if (cnt_s == 16'd15) chk("s_strobe_15", 32'(stb_s), 1);
    end
    chk("end_count", 32'(cnt), 799);
    chk("strobe_pulses", 32'(pulses), 2);
    chk("hsync_low_cycles", 32'(hs_low), 192);
    // 1599 small-instance cycles: 99 full periods of 3 sync cycles, plus the
    // partial period ending at count 15 which also covers 10..12.
    chk("s_hsync_high_cycles", 32'(s_hs_high), 300);

    // Freeze at the last column for 5 cycles, then resume.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1);
      chk("freeze_count", 32'(cnt), 799);
      chk("freeze_strobe", 32'(stb), 0);
    end
    step(1'b1, 1'b1);
    chk("resume_count", 32'(cnt), 0);
    chk("resume_strobe", 32'(stb), 0);

    // Reset in the middle of the sync pulse.
    for (int k = 0; k < 800 && cnt != 16'd700; k++) step(1'b1, 1'b1);
    chk("reach_700", 32'(cnt), 700);
    chk("hsync_at_700", 32'(hs), 0);
    pulse_reset(1'b1, 1'b0);
    chk("midline_rst_hsync", 32'(hs), 1);
    chk("midline_rst_count", 32'(cnt), 0);

    // Random run gaps and occasional asynchronous resets.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom % 10) != 0, ($urandom % 6) != 0);
      if (($urandom % 500) == 0) begin
        bit a;
        a = $urandom % 2;
        pulse_reset(a, !a || (($urandom % 2) == 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
